// File: rtl/combat_damage_scheduler_pkg.sv
// Shared game constants, scheduler state encoding and the saturating damage adder.
package combat_damage_scheduler_pkg;

   localparam int NUM_UNITS = 16;
   localparam int IDX_W     = 4;
   localparam int SEL_W     = 5;
   localparam int ATK_W     = 8;
   localparam int DMG_W     = 9;

   localparam logic [SEL_W-1:0] TOWER_SEL = 5'd16;
   localparam logic [SEL_W-1:0] NO_TARGET = 5'd31;
   localparam logic [DMG_W-1:0] DMG_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      APPLY,
      DONE
   } SchedState;

   // Damage totals clamp at the top of the 9-bit range instead of wrapping.
   function automatic logic [DMG_W-1:0] satAdd(input logic [DMG_W-1:0] acc,
                                               input logic [ATK_W-1:0] atk);
      logic [DMG_W:0] sum;
      sum = {1'b0, acc} + {2'b00, atk};
      return sum[DMG_W] ? DMG_MAX : sum[DMG_W-1:0];
   endfunction

endpackage

// File: rtl/combat_damage_scheduler_if.sv
// Bundle between the tick scheduler, the front/stat providers and the DamageDecoder.
interface combat_damage_scheduler_if;
   import combat_damage_scheduler_pkg::*;

   logic                 Start;
   logic [SEL_W-1:0]     friendlyFront;
   logic [SEL_W-1:0]     enemyFront;
   logic                 frontValid;
   logic [NUM_UNITS-1:0] unitAlive;
   logic [NUM_UNITS-1:0] enemyAlive;
   logic [NUM_UNITS-1:0] unitInRange;
   logic [NUM_UNITS-1:0] enemyInRange;
   logic [IDX_W-1:0]     attackIdx;
   logic [ATK_W-1:0]     unitAttack;
   logic [ATK_W-1:0]     enemyAttack;
   logic [SEL_W-1:0]     unitDamageSelect;
   logic [SEL_W-1:0]     enemyDamageSelect;
   logic [DMG_W-1:0]     totalUnitDamage;
   logic [DMG_W-1:0]     totalEnemyDamage;
   logic                 applyDamage;
   logic                 Busy;
   logic                 Done;

   modport master (
      output Start, friendlyFront, enemyFront, frontValid,
      output unitAlive, enemyAlive, unitInRange, enemyInRange,
      output unitAttack, enemyAttack,
      input  attackIdx, unitDamageSelect, enemyDamageSelect,
      input  totalUnitDamage, totalEnemyDamage, applyDamage, Busy, Done
   );

   modport slave (
      input  Start, friendlyFront, enemyFront, frontValid,
      input  unitAlive, enemyAlive, unitInRange, enemyInRange,
      input  unitAttack, enemyAttack,
      output attackIdx, unitDamageSelect, enemyDamageSelect,
      output totalUnitDamage, totalEnemyDamage, applyDamage, Busy, Done
   );

endinterface

// File: rtl/combat_damage_scheduler_cooldown_bank.sv
// One side's per-unit attack cooldowns; only the slot currently being scanned is updated.
module combat_damage_scheduler_cooldown_bank
   import combat_damage_scheduler_pkg::*;
#(
   parameter int COOLDOWN_TICKS = 4,
   parameter int CD_W           = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [IDX_W-1:0] idx,
   input  logic             step,
   input  logic             fire,
   input  logic             alive,
   output logic             ready
);

   localparam logic [CD_W-1:0] RELOAD = CD_W'(COOLDOWN_TICKS - 1);

   logic [CD_W-1:0] cnt [NUM_UNITS];

   // A dead slot never carries a pending cooldown into its next life.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            cnt[i] <= '0;
         end
      end else if (step) begin
         if (!alive) begin
            cnt[idx] <= '0;
         end else if (fire) begin
            cnt[idx] <= RELOAD;
         end else if (cnt[idx] != '0) begin
            cnt[idx] <= cnt[idx] - CD_W'(1);
         end
      end
   end

   assign ready = (cnt[idx] == '0);

endmodule

// File: rtl/combat_damage_scheduler.sv
// Per-tick damage sequencer: scans both armies slot by slot, sums firing attack, then strobes the decoder.
module combat_damage_scheduler
   import combat_damage_scheduler_pkg::*;
#(
   parameter int COOLDOWN_TICKS = 4,
   parameter int CD_W           = 3
) (
   input logic                      Clk,
   input logic                      Reset,
   combat_damage_scheduler_if.slave bus
);

   SchedState        state, nextState;
   logic [IDX_W-1:0] idx;
   logic [SEL_W-1:0] friendlyFrontQ, enemyFrontQ;
   logic             frontValidQ;
   logic [DMG_W-1:0] accUnit, accEnemy;
   logic             scanning, applying;
   logic             unitTargetOk, enemyTargetOk;
   logic             unitReady, enemyReady;
   logic             unitFire, enemyFire;

   assign scanning = (state == SCAN);
   assign applying = (state == APPLY);

   // Friendly units strike the enemy front and vice versa; fronts above the tower mean nothing to hit.
   assign unitTargetOk  = frontValidQ && (enemyFrontQ <= TOWER_SEL);
   assign enemyTargetOk = frontValidQ && (friendlyFrontQ <= TOWER_SEL);

   assign unitFire  = scanning && bus.unitAlive[idx] && bus.unitInRange[idx]
                      && unitReady && unitTargetOk;
   assign enemyFire = scanning && bus.enemyAlive[idx] && bus.enemyInRange[idx]
                      && enemyReady && enemyTargetOk;

   combat_damage_scheduler_cooldown_bank #(
      .COOLDOWN_TICKS(COOLDOWN_TICKS),
      .CD_W          (CD_W)
   ) unitCooldowns (
      .Clk  (Clk),
      .Reset(Reset),
      .idx  (idx),
      .step (scanning),
      .fire (unitFire),
      .alive(bus.unitAlive[idx]),
      .ready(unitReady)
   );

   combat_damage_scheduler_cooldown_bank #(
      .COOLDOWN_TICKS(COOLDOWN_TICKS),
      .CD_W          (CD_W)
   ) enemyCooldowns (
      .Clk  (Clk),
      .Reset(Reset),
      .idx  (idx),
      .step (scanning),
      .fire (enemyFire),
      .alive(bus.enemyAlive[idx]),
      .ready(enemyReady)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.Start) nextState = SCAN;
         SCAN:    if (idx == IDX_W'(NUM_UNITS - 1)) nextState = APPLY;
         APPLY:   nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Fronts are captured once per tick so upstream can move on while the scan runs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx            <= '0;
         friendlyFrontQ <= NO_TARGET;
         enemyFrontQ    <= NO_TARGET;
         frontValidQ    <= 1'b0;
         accUnit        <= '0;
         accEnemy       <= '0;
      end else if (state == IDLE && bus.Start) begin
         idx            <= '0;
         friendlyFrontQ <= bus.friendlyFront;
         enemyFrontQ    <= bus.enemyFront;
         frontValidQ    <= bus.frontValid;
         accUnit        <= '0;
         accEnemy       <= '0;
      end else if (scanning) begin
         idx <= idx + IDX_W'(1);
         if (unitFire) begin
            accEnemy <= satAdd(accEnemy, bus.unitAttack);
         end
         if (enemyFire) begin
            accUnit <= satAdd(accUnit, bus.enemyAttack);
         end
      end
   end

   assign bus.attackIdx         = idx;
   assign bus.applyDamage       = applying;
   assign bus.Busy              = (state != IDLE);
   assign bus.Done              = (state == DONE);
   assign bus.unitDamageSelect  = (applying && enemyTargetOk) ? friendlyFrontQ : NO_TARGET;
   assign bus.totalUnitDamage   = (applying && enemyTargetOk) ? accUnit : '0;
   assign bus.enemyDamageSelect = (applying && unitTargetOk) ? enemyFrontQ : NO_TARGET;
   assign bus.totalEnemyDamage  = (applying && unitTargetOk) ? accEnemy : '0;

endmodule

// File: tb/tb_combat_damage_scheduler.sv
// Directed bench for combat_damage_scheduler: one task per scenario with hand-computed expectations.
module tb_combat_damage_scheduler;
   import combat_damage_scheduler_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   combat_damage_scheduler_if bus();

   combat_damage_scheduler #(
      .COOLDOWN_TICKS(4),
      .CD_W          (3)
   ) dut (
      .Clk  (clk),
      .Reset(reset),
      .bus  (bus)
   );

   logic [7:0] unitAtkTable  [16];
   logic [7:0] enemyAtkTable [16];

   // Unit-stat lookup answers combinationally for whatever slot the scheduler points at.
   assign bus.unitAttack  = unitAtkTable[bus.attackIdx];
   assign bus.enemyAttack = enemyAtkTable[bus.attackIdx];

   int checks = 0;
   int passes = 0;

   int         applyCount, doneCount, applyCycle, doneCycle;
   int         busyCount, busyFirst, busyLast, idxErrors, quietErrors;
   logic [4:0] aUSel, aESel, sUSel, sESel;
   logic [8:0] aUTot, aETot, sUTot, sETot;
   logic       sApply, sBusy, sDone;
   logic [3:0] sIdx;

   task automatic doReset();
      reset     = 1'b1;
      bus.Start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic setUnits(input logic [15:0] uAlive, input logic [15:0] uRange,
                           input logic [15:0] eAlive, input logic [15:0] eRange);
      bus.unitAlive    = uAlive;
      bus.unitInRange  = uRange;
      bus.enemyAlive   = eAlive;
      bus.enemyInRange = eRange;
   endtask

   task automatic slotThreeSetup();
      setUnits(16'h0008, 16'h0008, 16'h0008, 16'h0008);
      for (int i = 0; i < 16; i++) begin
         unitAtkTable[i]  = 8'd50;
         enemyAtkTable[i] = 8'd60;
      end
      unitAtkTable[3]  = 8'd10;
      enemyAtkTable[3] = 8'd20;
   endtask

   // Start at cycle T, then watch T+1..T+19; fronts are scrambled after Start to prove latching.
   task automatic runTick(input logic [4:0] fFront, input logic [4:0] eFront, input logic valid,
                          input int extraStartAt, input int resetAt);
      @(negedge clk);
      bus.friendlyFront = fFront;
      bus.enemyFront    = eFront;
      bus.frontValid    = valid;
      bus.Start         = 1'b1;
      applyCount = 0; doneCount = 0; applyCycle = -1; doneCycle = -1;
      busyCount = 0; busyFirst = -1; busyLast = -1; idxErrors = 0; quietErrors = 0;
      aUSel = 5'd0; aESel = 5'd0; aUTot = 9'd0; aETot = 9'd0;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (bus.applyDamage) begin
            applyCount++;
            applyCycle = c;
            aUSel = bus.unitDamageSelect;
            aESel = bus.enemyDamageSelect;
            aUTot = bus.totalUnitDamage;
            aETot = bus.totalEnemyDamage;
         end else if (bus.unitDamageSelect !== 5'd31 || bus.enemyDamageSelect !== 5'd31 ||
                      bus.totalUnitDamage !== 9'd0 || bus.totalEnemyDamage !== 9'd0) begin
            quietErrors++;
         end
         if (bus.Done) begin
            doneCount++;
            doneCycle = c;
         end
         if (bus.Busy) begin
            busyCount++;
            if (busyFirst < 0) busyFirst = c;
            busyLast = c;
         end
         if (resetAt < 0 && c <= 16 && bus.attackIdx !== 4'(c - 1)) idxErrors++;
         if (c == resetAt + 1) begin
            sUSel = bus.unitDamageSelect; sESel = bus.enemyDamageSelect;
            sUTot = bus.totalUnitDamage;  sETot = bus.totalEnemyDamage;
            sApply = bus.applyDamage; sBusy = bus.Busy; sDone = bus.Done; sIdx = bus.attackIdx;
         end
         bus.Start = (c == extraStartAt);
         reset     = (c == resetAt);
         if (c == 1) begin
            bus.friendlyFront = 5'd9;
            bus.enemyFront    = 5'd11;
            bus.frontValid    = ~valid;
         end
      end
      bus.Start = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.unitDamageSelect !== 5'd31) $display("[TB] FAIL reset_usel: got %0d expected 31", bus.unitDamageSelect); else passes++;
      checks++; if (bus.enemyDamageSelect !== 5'd31) $display("[TB] FAIL reset_esel: got %0d expected 31", bus.enemyDamageSelect); else passes++;
      checks++; if (bus.totalUnitDamage !== 9'd0 || bus.totalEnemyDamage !== 9'd0) $display("[TB] FAIL reset_totals: got %0d/%0d expected 0/0", bus.totalUnitDamage, bus.totalEnemyDamage); else passes++;
      checks++; if ({bus.applyDamage, bus.Busy, bus.Done} !== 3'b000) $display("[TB] FAIL reset_strobes: got %b expected 000", {bus.applyDamage, bus.Busy, bus.Done}); else passes++;
      checks++; if (bus.attackIdx !== 4'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", bus.attackIdx); else passes++;
      reset = 1'b0;
   endtask

   task automatic test_single_fire();
      doReset();
      slotThreeSetup();
      runTick(5'd5, 5'd7, 1'b1, -1, -1);
      checks++; if (applyCycle !== 17) $display("[TB] FAIL single_apply_cycle: got %0d expected 17", applyCycle); else passes++;
      checks++; if (aESel !== 5'd7 || aETot !== 9'd10) $display("[TB] FAIL single_enemy: got sel %0d tot %0d expected sel 7 tot 10", aESel, aETot); else passes++;
      checks++; if (aUSel !== 5'd5 || aUTot !== 9'd20) $display("[TB] FAIL single_unit: got sel %0d tot %0d expected sel 5 tot 20", aUSel, aUTot); else passes++;
      checks++; if (doneCycle !== 18 || doneCount !== 1) $display("[TB] FAIL single_done: got cycle %0d count %0d expected 18/1", doneCycle, doneCount); else passes++;
      checks++; if (busyFirst !== 1 || busyLast !== 18 || busyCount !== 18) $display("[TB] FAIL single_busy: got %0d..%0d (%0d) expected 1..18 (18)", busyFirst, busyLast, busyCount); else passes++;
      checks++; if (idxErrors !== 0) $display("[TB] FAIL single_attack_idx: got %0d bad cycles expected 0", idxErrors); else passes++;
      checks++; if (quietErrors !== 0) $display("[TB] FAIL single_quiet_outputs: got %0d noisy cycles expected 0", quietErrors); else passes++;
   endtask

   task automatic test_cooldown();
      logic [8:0] expE [5];
      logic [8:0] expU [5];
      expE = '{9'd10, 9'd0, 9'd0, 9'd0, 9'd10};
      expU = '{9'd20, 9'd0, 9'd0, 9'd0, 9'd20};
      doReset();
      slotThreeSetup();
      for (int t = 0; t < 5; t++) begin
         runTick(5'd5, 5'd7, 1'b1, -1, -1);
         checks++; if (aETot !== expE[t] || aUTot !== expU[t]) $display("[TB] FAIL cooldown_tick%0d: got %0d/%0d expected %0d/%0d", t + 1, aETot, aUTot, expE[t], expU[t]); else passes++;
      end
   endtask

   task automatic test_mixed();
      doReset();
      setUnits(16'hA5F0, 16'hFF0F, 16'h0F0F, 16'h3333);
      for (int i = 0; i < 16; i++) begin
         unitAtkTable[i]  = 8'(i * 3);
         enemyAtkTable[i] = 8'(i + 20);
      end
      runTick(5'd16, 5'd15, 1'b1, -1, -1);
      checks++; if (aESel !== 5'd15 || aETot !== 9'd138) $display("[TB] FAIL mixed_enemy: got sel %0d tot %0d expected sel 15 tot 138", aESel, aETot); else passes++;
      checks++; if (aUSel !== 5'd16 || aUTot !== 9'd98) $display("[TB] FAIL mixed_unit: got sel %0d tot %0d expected sel 16 tot 98", aUSel, aUTot); else passes++;
      doReset();
      runTick(5'd20, 5'd4, 1'b1, -1, -1);
      checks++; if (aUSel !== 5'd31 || aUTot !== 9'd0) $display("[TB] FAIL oneside_unit: got sel %0d tot %0d expected sel 31 tot 0", aUSel, aUTot); else passes++;
      checks++; if (aESel !== 5'd4 || aETot !== 9'd138) $display("[TB] FAIL oneside_enemy: got sel %0d tot %0d expected sel 4 tot 138", aESel, aETot); else passes++;
   endtask

   task automatic test_saturation();
      doReset();
      setUnits(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 16; i++) begin
         unitAtkTable[i]  = 8'd255;
         enemyAtkTable[i] = 8'd3;
      end
      runTick(5'd2, 5'd16, 1'b1, -1, -1);
      checks++; if (aESel !== 5'd16 || aETot !== 9'd511) $display("[TB] FAIL sat_enemy: got sel %0d tot %0d expected sel 16 tot 511", aESel, aETot); else passes++;
      checks++; if (aUSel !== 5'd2 || aUTot !== 9'd48) $display("[TB] FAIL sat_unit: got sel %0d tot %0d expected sel 2 tot 48", aUSel, aUTot); else passes++;
   endtask

   task automatic test_no_target();
      doReset();
      slotThreeSetup();
      runTick(5'd5, 5'd7, 1'b0, -1, -1);
      checks++; if (aUSel !== 5'd31 || aESel !== 5'd31) $display("[TB] FAIL notarget_sel: got %0d/%0d expected 31/31", aUSel, aESel); else passes++;
      checks++; if (aUTot !== 9'd0 || aETot !== 9'd0 || applyCount !== 1) $display("[TB] FAIL notarget_tot: got %0d/%0d applies %0d expected 0/0 applies 1", aUTot, aETot, applyCount); else passes++;
      runTick(5'd5, 5'd7, 1'b1, -1, -1);
      checks++; if (aETot !== 9'd10 || aUTot !== 9'd20) $display("[TB] FAIL notarget_next: got %0d/%0d expected 10/20", aETot, aUTot); else passes++;
   endtask

   task automatic test_back_to_back();
      doReset();
      slotThreeSetup();
      runTick(5'd5, 5'd7, 1'b1, 5, -1);
      checks++; if (applyCount !== 1 || doneCount !== 1) $display("[TB] FAIL busy_start_ignored: got applies %0d dones %0d expected 1/1", applyCount, doneCount); else passes++;
      checks++; if (applyCycle !== 17 || aETot !== 9'd10) $display("[TB] FAIL busy_apply: got cycle %0d tot %0d expected 17/10", applyCycle, aETot); else passes++;
   endtask

   task automatic test_reset_mid_scan();
      doReset();
      slotThreeSetup();
      runTick(5'd5, 5'd7, 1'b1, -1, 8);
      checks++; if (sUSel !== 5'd31 || sESel !== 5'd31 || sUTot !== 9'd0 || sETot !== 9'd0) $display("[TB] FAIL midreset_outputs: got %0d/%0d %0d/%0d expected 31/31 0/0", sUSel, sESel, sUTot, sETot); else passes++;
      checks++; if ({sApply, sBusy, sDone} !== 3'b000 || sIdx !== 4'd0) $display("[TB] FAIL midreset_state: got %b idx %0d expected 000 idx 0", {sApply, sBusy, sDone}, sIdx); else passes++;
      checks++; if (applyCount !== 0 || doneCount !== 0) $display("[TB] FAIL midreset_no_apply: got applies %0d dones %0d expected 0/0", applyCount, doneCount); else passes++;
      runTick(5'd5, 5'd7, 1'b1, -1, -1);
      checks++; if (aETot !== 9'd10 || aUTot !== 9'd20) $display("[TB] FAIL midreset_cooldown_clear: got %0d/%0d expected 10/20", aETot, aUTot); else passes++;
   endtask

   initial begin
      reset             = 1'b1;
      bus.Start         = 1'b0;
      bus.friendlyFront = 5'd31;
      bus.enemyFront    = 5'd31;
      bus.frontValid    = 1'b0;
      setUnits(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         unitAtkTable[i]  = 8'd0;
         enemyAtkTable[i] = 8'd0;
      end
      test_reset();
      test_single_fire();
      test_cooldown();
      test_mixed();
      test_saturation();
      test_no_target();
      test_back_to_back();
      test_reset_mid_scan();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
